// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared types and helpers for the TCP connection controller
package tcp_pkg;

  typedef enum logic [2:0] {
    RX_MSG_NOP,
    RX_MSG_RECV_SYNACK,
    RX_MSG_RECV_ACK,
    RX_MSG_RECV_FIN,
    RX_MSG_RECV_FINACK,
    RX_MSG_RECV_RST
  } rx_msg_t;

  typedef enum logic [1:0] {
    TX_CTRL_NOP,
    TX_CTRL_SEND_SYN,
    TX_CTRL_SEND_ACK,
    TX_CTRL_SEND_FIN
  } tx_ctrl_t;

  typedef enum logic [2:0] {
    TCP_CLOSED,
    TCP_SYN_SENT,
    TCP_ESTABLISHED,
    TCP_FIN_WAIT_1,
    TCP_FIN_WAIT_2,
    TCP_TIME_WAIT,
    TCP_CLOSE_WAIT,
    TCP_LAST_ACK
  } tcp_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // States whose dwell is bounded by the shared timer.
  function automatic logic is_timed(input tcp_state_t s);
    return (s == TCP_SYN_SENT) || (s == TCP_FIN_WAIT_1) ||
           (s == TCP_LAST_ACK) || (s == TCP_TIME_WAIT);
  endfunction

endpackage

// File: rtl/tcp_conn_timer.sv
// rtl/tcp_conn_timer.sv - saturating counter with clear, enable and terminal-count compare
module tcp_conn_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_tc,
  output logic         o_expire
);

  localparam logic [W:0] ONE_EXT = (W + 1)'(1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires in the cycle whose increment would reach the terminal count, so the
  // consequence lands exactly i_tc cycles after the clear.
  assign o_expire = i_en && (({1'b0, count_q} + ONE_EXT) >= {1'b0, i_tc});

endmodule

// File: rtl/tcp_conn_fsm.sv
// rtl/tcp_conn_fsm.sv - connection-level TCP state machine with retransmit and TIME_WAIT timing
module tcp_conn_fsm
  import tcp_pkg::*;
#(
  parameter int RTO_CYCLES       = 1000000,
  parameter int MAX_RETRIES      = 3,
  parameter int TIME_WAIT_CYCLES = 2000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_open,
  input  logic       i_close,
  input  rx_msg_t    i_rx_msg,
  input  logic       i_rx_msg_valid,
  output logic       o_rx_msg_ack,
  output tx_ctrl_t   o_tx_ctrl,
  output logic       o_tx_ctrl_valid,
  input  logic       i_tx_ctrl_ack,
  output tcp_state_t o_state,
  output logic       o_established,
  output logic       o_error
);

  localparam int TMR_W = $clog2(max_int(RTO_CYCLES, TIME_WAIT_CYCLES) + 1);
  localparam int RTY_W = max_int(1, $clog2(MAX_RETRIES + 1));

  tcp_state_t       state_q, state_d;
  tx_ctrl_t         tx_ctrl_q, tx_ctrl_d;
  logic             tx_valid_q, tx_valid_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             error_q, error_d;

  logic             rx_take, tx_done, tx_free, retx_armed;
  logic             tmr_clear, tmr_en, tmr_expire;
  logic [TMR_W-1:0] tmr_tc;
  tx_ctrl_t         retx_seg;

  assign rx_take  = i_rx_msg_valid & ~tx_valid_q;
  assign tx_done  = tx_valid_q & i_tx_ctrl_ack;
  assign tx_free  = ~tx_valid_q | i_tx_ctrl_ack;
  assign retx_seg = (state_q == TCP_SYN_SENT) ? TX_CTRL_SEND_SYN : TX_CTRL_SEND_FIN;

  // Every timed state is entered with a segment pending, so the timer only
  // starts once that segment is accepted.
  assign tmr_tc    = (state_q == TCP_TIME_WAIT) ? TMR_W'(TIME_WAIT_CYCLES) : TMR_W'(RTO_CYCLES);
  assign tmr_en    = is_timed(state_q) & ~tx_valid_q;
  assign tmr_clear = tx_done | (state_d != state_q);

  tcp_conn_timer #(.W(TMR_W)) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (tmr_clear),
    .i_en     (tmr_en),
    .i_tc     (tmr_tc),
    .o_expire (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q & ~i_tx_ctrl_ack;
    tx_ctrl_d  = tx_done ? TX_CTRL_NOP : tx_ctrl_q;
    retry_d    = retry_q;
    error_d    = 1'b0;
    retx_armed = 1'b0;

    case (state_q)
      TCP_CLOSED: begin
        if (i_open) begin
          state_d    = TCP_SYN_SENT;
          tx_valid_d = 1'b1;
          tx_ctrl_d  = TX_CTRL_SEND_SYN;
          retry_d    = '0;
        end
      end
      TCP_SYN_SENT: begin
        if (rx_take && (i_rx_msg == RX_MSG_RECV_SYNACK)) begin
          state_d    = TCP_ESTABLISHED;
          tx_valid_d = 1'b1;
          tx_ctrl_d  = TX_CTRL_SEND_ACK;
        end else begin
          retx_armed = 1'b1;
        end
      end
      TCP_ESTABLISHED: begin
        if (rx_take && (i_rx_msg == RX_MSG_RECV_FIN)) begin
          state_d    = TCP_CLOSE_WAIT;
          tx_valid_d = 1'b1;
          tx_ctrl_d  = TX_CTRL_SEND_ACK;
        end else if (i_close && tx_free) begin
          state_d    = TCP_FIN_WAIT_1;
          tx_valid_d = 1'b1;
          tx_ctrl_d  = TX_CTRL_SEND_FIN;
          retry_d    = '0;
        end
      end
      TCP_FIN_WAIT_1: begin
        if (rx_take && (i_rx_msg == RX_MSG_RECV_ACK)) begin
          state_d = TCP_FIN_WAIT_2;
        end else if (rx_take && (i_rx_msg == RX_MSG_RECV_FINACK)) begin
          state_d    = TCP_TIME_WAIT;
          tx_valid_d = 1'b1;
          tx_ctrl_d  = TX_CTRL_SEND_ACK;
        end else begin
          retx_armed = 1'b1;
        end
      end
      TCP_FIN_WAIT_2: begin
        if (rx_take && (i_rx_msg == RX_MSG_RECV_FIN)) begin
          state_d    = TCP_TIME_WAIT;
          tx_valid_d = 1'b1;
          tx_ctrl_d  = TX_CTRL_SEND_ACK;
        end
      end
      TCP_TIME_WAIT: begin
        if (tmr_expire) begin
          state_d = TCP_CLOSED;
        end
      end
      TCP_CLOSE_WAIT: begin
        if (tx_done) begin
          state_d    = TCP_LAST_ACK;
          tx_valid_d = 1'b1;
          tx_ctrl_d  = TX_CTRL_SEND_FIN;
          retry_d    = '0;
        end
      end
      TCP_LAST_ACK: begin
        if (rx_take && (i_rx_msg == RX_MSG_RECV_ACK)) begin
          state_d = TCP_CLOSED;
        end else begin
          retx_armed = 1'b1;
        end
      end
      default: state_d = TCP_CLOSED;
    endcase

    if (retx_armed && tmr_expire) begin
      if (retry_q < RTY_W'(MAX_RETRIES)) begin
        tx_valid_d = 1'b1;
        tx_ctrl_d  = retx_seg;
        retry_d    = retry_q + RTY_W'(1);
      end else begin
        state_d = TCP_CLOSED;
        error_d = 1'b1;
      end
    end

    // A peer reset overrides everything, including a coincident timeout.
    if (rx_take && (i_rx_msg == RX_MSG_RECV_RST) && (state_q != TCP_CLOSED)) begin
      state_d    = TCP_CLOSED;
      tx_valid_d = 1'b0;
      tx_ctrl_d  = TX_CTRL_NOP;
      error_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= TCP_CLOSED;
      tx_ctrl_q  <= TX_CTRL_NOP;
      tx_valid_q <= 1'b0;
      retry_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_ctrl_q  <= tx_ctrl_d;
      tx_valid_q <= tx_valid_d;
      retry_q    <= retry_d;
      error_q    <= error_d;
    end
  end

  assign o_rx_msg_ack    = rx_take;
  assign o_tx_ctrl       = tx_ctrl_q;
  assign o_tx_ctrl_valid = tx_valid_q;
  assign o_state         = state_q;
  assign o_established   = (state_q == TCP_ESTABLISHED);
  assign o_error         = error_q;

endmodule

// File: tb/tb_tcp_conn_fsm.sv
// tb/tb_tcp_conn_fsm.sv - randomized self-checking bench for tcp_conn_fsm
module tb_tcp_conn_fsm;
  import tcp_pkg::*;

  localparam int RTO     = 100;
  localparam int RETRIES = 3;
  localparam int TWAIT   = 50;

  logic       i_clk = 1'b0;
  logic       i_rst, i_open, i_close, i_rx_msg_valid, i_tx_ctrl_ack;
  rx_msg_t    i_rx_msg;
  logic       o_rx_msg_ack, o_tx_ctrl_valid, o_established, o_error;
  tx_ctrl_t   o_tx_ctrl;
  tcp_state_t o_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  tcp_state_t m_st;
  logic       m_pend, m_err;
  tx_ctrl_t   m_seg;
  int         m_retries;
  int         m_deadline = -1;

  always #5 i_clk = ~i_clk;

  tcp_conn_fsm #(
    .RTO_CYCLES       (RTO),
    .MAX_RETRIES      (RETRIES),
    .TIME_WAIT_CYCLES (TWAIT)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_open          (i_open),
    .i_close         (i_close),
    .i_rx_msg        (i_rx_msg),
    .i_rx_msg_valid  (i_rx_msg_valid),
    .o_rx_msg_ack    (o_rx_msg_ack),
    .o_tx_ctrl       (o_tx_ctrl),
    .o_tx_ctrl_valid (o_tx_ctrl_valid),
    .i_tx_ctrl_ack   (i_tx_ctrl_ack),
    .o_state         (o_state),
    .o_established   (o_established),
    .o_error         (o_error)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: timed waits are modelled as an absolute deadline cycle set when
  // the outstanding segment is accepted.
  task automatic model_step(input logic rst, input logic op, input logic cl,
                            input rx_msg_t msg, input logic mv, input logic ack);
    logic take, fire, np, ne;
    tcp_state_t nst;
    tx_ctrl_t ns;
    if (rst) begin
      m_st = TCP_CLOSED; m_pend = 0; m_seg = TX_CTRL_NOP; m_err = 0; m_retries = 0;
      return;
    end
    take = mv && !m_pend;
    fire = !m_pend && (cyc == m_deadline) &&
           (m_st inside {TCP_SYN_SENT, TCP_FIN_WAIT_1, TCP_LAST_ACK, TCP_TIME_WAIT});
    if (m_pend && ack) m_deadline = cyc + ((m_st == TCP_TIME_WAIT) ? TWAIT : RTO);
    nst = m_st;
    np  = m_pend && !ack;
    ns  = np ? m_seg : TX_CTRL_NOP;
    ne  = 0;
    if (take && msg == RX_MSG_RECV_RST && m_st != TCP_CLOSED) begin
      nst = TCP_CLOSED;
    end else begin
      case (m_st)
        TCP_CLOSED: if (op) begin nst = TCP_SYN_SENT; np = 1; ns = TX_CTRL_SEND_SYN; m_retries = 0; end
        TCP_SYN_SENT:
          if (take && msg == RX_MSG_RECV_SYNACK) begin nst = TCP_ESTABLISHED; np = 1; ns = TX_CTRL_SEND_ACK; end
          else if (fire) begin
            if (m_retries < RETRIES) begin np = 1; ns = TX_CTRL_SEND_SYN; m_retries++; end
            else begin nst = TCP_CLOSED; ne = 1; end
          end
        TCP_ESTABLISHED:
          if (take && msg == RX_MSG_RECV_FIN) begin nst = TCP_CLOSE_WAIT; np = 1; ns = TX_CTRL_SEND_ACK; end
          else if (cl && (!m_pend || ack)) begin
            nst = TCP_FIN_WAIT_1; np = 1; ns = TX_CTRL_SEND_FIN; m_retries = 0;
          end
        TCP_FIN_WAIT_1:
          if (take && msg == RX_MSG_RECV_ACK) nst = TCP_FIN_WAIT_2;
          else if (take && msg == RX_MSG_RECV_FINACK) begin nst = TCP_TIME_WAIT; np = 1; ns = TX_CTRL_SEND_ACK; end
          else if (fire) begin
            if (m_retries < RETRIES) begin np = 1; ns = TX_CTRL_SEND_FIN; m_retries++; end
            else begin nst = TCP_CLOSED; ne = 1; end
          end
        TCP_FIN_WAIT_2:
          if (take && msg == RX_MSG_RECV_FIN) begin nst = TCP_TIME_WAIT; np = 1; ns = TX_CTRL_SEND_ACK; end
        TCP_TIME_WAIT: if (fire) nst = TCP_CLOSED;
        TCP_CLOSE_WAIT:
          if (m_pend && ack) begin nst = TCP_LAST_ACK; np = 1; ns = TX_CTRL_SEND_FIN; m_retries = 0; end
        TCP_LAST_ACK:
          if (take && msg == RX_MSG_RECV_ACK) nst = TCP_CLOSED;
          else if (fire) begin
            if (m_retries < RETRIES) begin np = 1; ns = TX_CTRL_SEND_FIN; m_retries++; end
            else begin nst = TCP_CLOSED; ne = 1; end
          end
        default: ;
      endcase
    end
    m_st = nst; m_pend = np; m_seg = ns; m_err = ne;
  endtask

  task automatic tick(input logic rst, input logic op, input logic cl,
                      input rx_msg_t msg, input logic mv, input logic ack);
    i_rst = rst; i_open = op; i_close = cl; i_rx_msg = msg;
    i_rx_msg_valid = mv; i_tx_ctrl_ack = ack;
    #4;
    check("state", o_state, m_st);
    check("tx_ctrl", o_tx_ctrl, m_seg);
    check("tx_valid", o_tx_ctrl_valid, m_pend);
    check("established", o_established, m_st == TCP_ESTABLISHED);
    check("error", o_error, m_err);
    check("rx_ack", o_rx_msg_ack, mv && !m_pend);
    model_step(rst, op, cl, msg, mv, ack);
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) tick(0, 0, 0, RX_MSG_NOP, 0, ack);
  endtask

  task automatic rx(input rx_msg_t msg);
    tick(0, 0, 0, msg, 1, 0);
  endtask

  task automatic open_conn();
    tick(0, 1, 0, RX_MSG_NOP, 0, 0);
    check("open_seg", o_tx_ctrl, TX_CTRL_SEND_SYN);
    check("open_valid", o_tx_ctrl_valid, 1);
    idle(2, 0);
    idle(1, 1);
    rx(RX_MSG_RECV_SYNACK);
    check("synack_seg", o_tx_ctrl, TX_CTRL_SEND_ACK);
    idle(1, 1);
    check("open_established", o_established, 1);
  endtask

  initial begin
    int k, syn_cnt, err_cnt, since_ack;
    i_rst = 1; i_open = 0; i_close = 0; i_rx_msg = RX_MSG_NOP;
    i_rx_msg_valid = 0; i_tx_ctrl_ack = 0;
    repeat (2) @(posedge i_clk);
    #1;
    model_step(1, 0, 0, RX_MSG_NOP, 0, 0);
    tick(1, 0, 0, RX_MSG_NOP, 0, 0);
    check("rst_state", o_state, TCP_CLOSED);
    check("rst_tx_ctrl", o_tx_ctrl, TX_CTRL_NOP);

    // Open, then active close through TIME_WAIT.
    open_conn();
    tick(0, 0, 1, RX_MSG_NOP, 0, 0);
    check("close_seg", o_tx_ctrl, TX_CTRL_SEND_FIN);
    idle(1, 1);
    check("fw1", o_state, TCP_FIN_WAIT_1);
    rx(RX_MSG_RECV_ACK);
    check("fw2", o_state, TCP_FIN_WAIT_2);
    rx(RX_MSG_RECV_FIN);
    check("tw_state", o_state, TCP_TIME_WAIT);
    check("tw_seg", o_tx_ctrl, TX_CTRL_SEND_ACK);
    idle(1, 1);
    k = 0;
    while (o_state != TCP_CLOSED && k < 200) begin idle(1, 0); k++; end
    check("time_wait_len", k, TWAIT);

    // Passive close.
    open_conn();
    rx(RX_MSG_RECV_FIN);
    check("pc_close_wait", o_state, TCP_CLOSE_WAIT);
    idle(1, 1);
    check("pc_last_ack", o_state, TCP_LAST_ACK);
    check("pc_fin", o_tx_ctrl, TX_CTRL_SEND_FIN);
    idle(1, 1);
    rx(RX_MSG_RECV_ACK);
    check("pc_closed", o_state, TCP_CLOSED);

    // Retry exhaustion.
    tick(0, 1, 0, RX_MSG_NOP, 0, 0);
    syn_cnt = 0; err_cnt = 0; since_ack = -1; k = 0;
    while (o_state != TCP_CLOSED && k < 1000) begin
      if (o_tx_ctrl_valid && o_tx_ctrl == TX_CTRL_SEND_SYN) begin
        syn_cnt++;
        if (since_ack >= 0) check("rto_gap", since_ack, RTO);
        idle(1, 1);
        since_ack = 0;
      end else begin
        idle(1, 0);
        if (since_ack >= 0) since_ack++;
      end
      if (o_error) err_cnt++;
      k++;
    end
    check("syn_count", syn_cnt, RETRIES + 1);
    check("abandon_gap", since_ack, RTO);
    check("abandon_error", err_cnt, 1);
    idle(1, 0);
    check("error_one_cycle", o_error, 0);

    // Backpressure on a pending ACK with a FIN waiting.
    tick(0, 1, 0, RX_MSG_NOP, 0, 0);
    idle(1, 1);
    rx(RX_MSG_RECV_SYNACK);
    for (int i = 0; i < 20; i++) begin
      rx(RX_MSG_RECV_FIN);
      check("bp_rx_ack", o_rx_msg_ack, 0);
      check("bp_ctrl_stable", o_tx_ctrl, TX_CTRL_SEND_ACK);
    end
    tick(0, 0, 0, RX_MSG_RECV_FIN, 1, 1);
    rx(RX_MSG_RECV_FIN);
    check("bp_close_wait", o_state, TCP_CLOSE_WAIT);
    idle(2, 1);
    rx(RX_MSG_RECV_ACK);

    // Reset with a SYN pending; RST from ESTABLISHED.
    tick(0, 1, 0, RX_MSG_NOP, 0, 0);
    idle(1, 0);
    tick(1, 0, 0, RX_MSG_NOP, 0, 0);
    check("rstp_state", o_state, TCP_CLOSED);
    check("rstp_valid", o_tx_ctrl_valid, 0);
    check("rstp_ctrl", o_tx_ctrl, TX_CTRL_NOP);
    open_conn();
    rx(RX_MSG_RECV_RST);
    check("rst_msg_state", o_state, TCP_CLOSED);
    check("rst_msg_error", o_error, 0);
    check("rst_msg_valid", o_tx_ctrl_valid, 0);

    // Random traffic: dense, then sparse receive so timeouts occur.
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           rx_msg_t'($urandom_range(0, 5)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    for (int i = 0; i < 4000; i++)
      tick($urandom_range(0, 1999) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
           rx_msg_t'($urandom_range(0, 5)), $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
